ay_bus_master: RTL and testbench

- Bus initiator that drives the BDIR/BC/data bus of the on-chip ym2149 PSG.
- Accepts register write/read requests from the host side (Z80 port decode or a register-dump player) through a valid/ready handshake and queues them in a small FIFO.
- Sequences each request into the address-latch phase followed by the write or read phase.
- Returns read data with a one-cycle response strobe. It sits between the CPU port decoder and the ym2149 instance.

---
 rtl/ay_bus_pkg.sv | 16 +
 rtl/ay_bus_master_if.sv | 23 ++
 rtl/ay_req_fifo.sv | 40 ++++
 rtl/ay_bus_master.sv | 114 +++++++++++
 tb/tb_ay_bus_master.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ay_bus_pkg.sv
// ay_bus_pkg: shared types and bus-mode encodings for the ym2149 bus master
package ay_bus_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, AGAP, DATA, DGAP} ay_bus_state_t;
  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;
  localparam logic [1:0] BUS_ADDR  = 2'b11;
  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } ay_req_t;
  function automatic int max2(int a, int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ay_bus_master_if.sv
// ay_bus_master_if: host request/response handshake plus PSG bus pins
interface ay_bus_master_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_WR;
  logic [3:0] REQ_ADDR;
  logic [7:0] REQ_DATA;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       BUSY;
  logic       BDIR;
  logic       BC;
  logic [7:0] PSG_DI;
  logic [7:0] PSG_DO;
  modport master (
    input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_DATA, PSG_DO,
    output REQ_READY, RSP_VALID, RSP_DATA, BUSY, BDIR, BC, PSG_DI
  );
  modport slave (
    output REQ_VALID, REQ_WR, REQ_ADDR, REQ_DATA, PSG_DO,
    input  REQ_READY, RSP_VALID, RSP_DATA, BUSY, BDIR, BC, PSG_DI
  );
endinterface

// File: rtl/ay_req_fifo.sv
// ay_req_fifo: show-ahead synchronous request FIFO with full/empty and next-cycle full flags
module ay_req_fifo
  import ay_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  ay_req_t wdata,
  input  logic    pop,
  output ay_req_t rdata,
  output logic    full,
  output logic    full_nxt,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  ay_req_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  assign wp_d = push ? wp_q + 1'b1 : wp_q;
  assign rp_d = pop ? rp_q + 1'b1 : rp_q;
  assign cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign full_nxt = cnt_d == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign rdata = mem_q[rp_q];
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ay_bus_master.sv
// ay_bus_master: queued BDIR/BC address/data sequencer for the ym2149 PSG; AY_ADDR_CACHE_EN skips re-latching an unchanged address
module ay_bus_master
  import ay_bus_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic CLK,
  input logic RESET,
  ay_bus_master_if.master bus
);
  localparam int CW = $clog2(max2(PULSE_W, GAP_W) + 1);
  localparam logic [CW-1:0] P_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_W - 1);
  ay_bus_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ay_req_t req_q, req_d, head, wdata;
  logic [1:0] mode_q, mode_d;
  logic [7:0] di_q, di_d, rsp_data_q, rsp_data_d;
  logic rsp_valid_q, rsp_valid_d, ready_q, push, pop, full, full_nxt, empty, hit;

  assign wdata = '{wr: bus.REQ_WR, addr: bus.REQ_ADDR, data: bus.REQ_DATA};
  assign push = bus.REQ_VALID & ready_q & ~full;

  ay_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK), .rst(RESET), .push, .wdata, .pop, .rdata(head), .full, .full_nxt, .empty
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
    req_d = req_q;
    pop = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        req_d = head;
        state_d = hit ? DATA : ADDR;
        cnt_d = P_LD;
      end
      ADDR: if (cnt_q == '0) begin
        state_d = AGAP;
        cnt_d = G_LD;
      end
      AGAP: if (cnt_q == '0) begin
        state_d = DATA;
        cnt_d = P_LD;
      end
      DATA: if (cnt_q == '0) begin
        state_d = DGAP;
        cnt_d = G_LD;
        rsp_valid_d = !req_q.wr;
        rsp_data_d = req_q.wr ? rsp_data_q : bus.PSG_DO;
      end
      DGAP: if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // bus pins are registered from the next state so they line up with state_q
    mode_d = state_d == ADDR ? BUS_ADDR :
             state_d == DATA ? (req_d.wr ? BUS_WRITE : BUS_READ) : BUS_IDLE;
    di_d = state_d == ADDR ? {4'h0, req_d.addr} :
           (state_d == DATA && req_d.wr) ? req_d.data : 8'h00;
  end

`ifdef AY_ADDR_CACHE_EN
  logic [3:0] cache_addr_q, cache_addr_d;
  logic cache_vld_q, cache_vld_d;
  assign cache_addr_d = state_d == ADDR ? req_d.addr : cache_addr_q;
  assign cache_vld_d = cache_vld_q | (state_d == ADDR);
  assign hit = cache_vld_q && head.addr == cache_addr_q;
  always_ff @(posedge CLK)
    if (RESET) begin
      cache_addr_q <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      cache_addr_q <= cache_addr_d;
      cache_vld_q <= cache_vld_d;
    end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge CLK)
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      req_q <= '0;
      mode_q <= BUS_IDLE;
      di_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      mode_q <= mode_d;
      di_q <= di_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      ready_q <= !full_nxt;
    end

  assign bus.BDIR = mode_q[1];
  assign bus.BC = mode_q[0];
  assign bus.PSG_DI = di_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA = rsp_data_q;
  assign bus.REQ_READY = ready_q;
  assign bus.BUSY = !empty || state_q != IDLE;
endmodule

// File: tb/tb_ay_bus_master.sv
// tb_ay_bus_master: scoreboard bench with a ym2149 bus model on a default and a PULSE_W=1 instance
module tb_ay_bus_master;
  import ay_bus_pkg::*;
  localparam int PW = 2;
  localparam int GW = 1;
`ifdef AY_ADDR_CACHE_EN
  localparam int EXP_AP = 1;
`else
  localparam int EXP_AP = 2;
`endif
  typedef struct {logic [1:0] m; logic [7:0] di;} ph_t;

  logic CLK = 0, RESET = 1;
  int n_chk = 0, n_fail = 0;
  ph_t exp_ph[$];
  logic [7:0] exp_rsp[$], exp_rsp1[$];
  int adr_t[$];
  logic [7:0] psg0[16], shd0[16], psg1[16], shd1[16];
  logic [3:0] pa0 = 0, pa1 = 0, mc_a = 0;
  logic mc_v = 0;
  logic [1:0] m0, m1, ph_mode, last_ph = BUS_IDLE, prev_m0 = BUS_IDLE, prev_m1 = BUS_IDLE;
  logic [7:0] ph_di;
  logic pb1 = 0;
  int cur_len = 0, gap_len = 100, cyc = 0, rises1 = 0;
  ph_t e;

  ay_bus_master_if b0(), b1();
  assign b0.PSG_DO = psg0[pa0];
  assign b1.PSG_DO = psg1[pa1];

  ay_bus_master #(.PULSE_W(PW), .GAP_W(GW), .FIFO_DEPTH(4)) u0 (.CLK(CLK), .RESET(RESET), .bus(b0));
  ay_bus_master #(.PULSE_W(1), .GAP_W(1), .FIFO_DEPTH(4)) u1 (.CLK(CLK), .RESET(RESET), .bus(b1));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bus model for instance 0: collapses the pins into phases and scores them
  always @(negedge CLK) begin
    cyc++;
    if (RESET) begin
      cur_len = 0;
      gap_len = 100;
      last_ph = BUS_IDLE;
      prev_m0 = BUS_IDLE;
    end else begin
      m0 = {b0.BDIR, b0.BC};
      if (b0.RSP_VALID) begin
        chk("rsp_timing", {prev_m0, m0}, {BUS_READ, BUS_IDLE});
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rsp_data", b0.RSP_DATA, exp_rsp.pop_front());
      end
      if (cur_len != 0 && (m0 != ph_mode || b0.PSG_DI != ph_di)) begin
        if (exp_ph.size() == 0) chk("ph_unexpected", 1, 0);
        else begin
          e = exp_ph.pop_front();
          chk("ph_mode", ph_mode, e.m);
          chk("ph_di", ph_di, e.di);
          chk("ph_len", cur_len, PW);
        end
        last_ph = ph_mode;
        cur_len = 0;
      end
      if (m0 != BUS_IDLE) begin
        if (m0 == BUS_ADDR) pa0 = b0.PSG_DI[3:0];
        else if (m0 == BUS_WRITE) psg0[pa0] = b0.PSG_DI;
        if (cur_len == 0) begin
          if (last_ph == BUS_ADDR) chk("agap_len", gap_len, GW);
          else chk("gap_min", gap_len >= GW, 1);
          if (m0 == BUS_ADDR) adr_t.push_back(cyc);
          ph_mode = m0;
          ph_di = b0.PSG_DI;
          cur_len = 1;
        end else cur_len++;
        gap_len = 0;
      end else gap_len++;
      prev_m0 = m0;
    end
  end

  // bus model for instance 1: phase separation, BDIR edges and read data
  always @(negedge CLK) begin
    if (RESET) prev_m1 = BUS_IDLE;
    else begin
      m1 = {b1.BDIR, b1.BC};
      if (m1 == BUS_ADDR) pa1 = b1.PSG_DI[3:0];
      else if (m1 == BUS_WRITE) psg1[pa1] = b1.PSG_DI;
      if (m1 != BUS_IDLE) chk("gap1", prev_m1, BUS_IDLE);
      if (b1.BDIR && !pb1) rises1++;
      if (b1.RSP_VALID) begin
        if (exp_rsp1.size() == 0) chk("rsp1_unexpected", 1, 0);
        else chk("rsp1_data", b1.RSP_DATA, exp_rsp1.pop_front());
      end
      prev_m1 = m1;
      pb1 = b1.BDIR;
    end
  end

  task automatic req(input bit u, input bit wr, input logic [3:0] a, input logic [7:0] d);
    bit acc, ok;
    ok = 0;
    if (u) begin b1.REQ_VALID = 1; b1.REQ_WR = wr; b1.REQ_ADDR = a; b1.REQ_DATA = d; end
    else begin b0.REQ_VALID = 1; b0.REQ_WR = wr; b0.REQ_ADDR = a; b0.REQ_DATA = d; end
    for (int i = 0; i < 300; i++) begin
      acc = u ? b1.REQ_READY : b0.REQ_READY;
      @(negedge CLK);
      if (acc) begin ok = 1; break; end
    end
    b0.REQ_VALID = 0;
    b1.REQ_VALID = 0;
    chk("req_accept", ok, 1);
    if (ok && u) begin
      if (wr) shd1[a] = d;
      else exp_rsp1.push_back(shd1[a]);
    end else if (ok) begin
      if (!(mc_v && mc_a == a)) exp_ph.push_back('{BUS_ADDR, {4'h0, a}});
`ifdef AY_ADDR_CACHE_EN
      mc_v = 1;
      mc_a = a;
`endif
      if (wr) begin
        exp_ph.push_back('{BUS_WRITE, d});
        shd0[a] = d;
      end else begin
        exp_ph.push_back('{BUS_READ, 8'h00});
        exp_rsp.push_back(shd0[a]);
      end
    end
  endtask

  task automatic wait_idle(input bit u);
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      #1;
      if (!(u ? b1.BUSY : b0.BUSY)) begin done = 1; break; end
    end
    chk("idle_timeout", done, 1);
    if (!u) begin
      chk("busy_fall", gap_len, GW + 1);
      chk("ph_drained", exp_ph.size(), 0);
    end
  endtask

  task automatic rst_pulse();
    RESET = 1;
    @(negedge CLK);
    @(negedge CLK);
    exp_ph.delete();
    exp_rsp.delete();
    mc_v = 0;
    RESET = 0;
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      psg0[i] = 8'h00;
      shd0[i] = 8'h00;
      psg1[i] = 8'(8'hC0 + i);
      shd1[i] = 8'(8'hC0 + i);
    end
    psg0[14] = 8'hA5;
    shd0[14] = 8'hA5;
    b0.REQ_VALID = 0; b0.REQ_WR = 0; b0.REQ_ADDR = 0; b0.REQ_DATA = 0;
    b1.REQ_VALID = 0; b1.REQ_WR = 0; b1.REQ_ADDR = 0; b1.REQ_DATA = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_bdir", b0.BDIR, 0);
    chk("rst_bc", b0.BC, 0);
    chk("rst_psg_di", b0.PSG_DI, 0);
    chk("rst_rsp_valid", b0.RSP_VALID, 0);
    chk("rst_rsp_data", b0.RSP_DATA, 0);
    chk("rst_busy", b0.BUSY, 0);
    chk("rst_ready", b0.REQ_READY, 0);
    RESET = 0;
    @(negedge CLK);
    chk("ready_post_rst", b0.REQ_READY, 1);
    req(0, 1, 4'd7, 8'h38);
    wait_idle(0);
    chk("psg_reg7", psg0[7], 8'h38);
    req(0, 0, 4'd14, 8'h00);
    wait_idle(0);
    chk("rsp_data_read14", b0.RSP_DATA, 8'hA5);
    adr_t.delete();
    for (int i = 0; i < 5; i++) req(0, 1, 4'(i + 1), 8'(8'h51 + i));
    chk("ready_full", b0.REQ_READY, 0);
    wait_idle(0);
    chk("burst_addr_phases", adr_t.size(), 5);
    for (int i = 1; i < adr_t.size(); i++) chk("occupancy", adr_t[i] - adr_t[i-1], 2 * (PW + GW) + 1);
    for (int i = 0; i < 5; i++) chk("burst_reg", psg0[i+1], 8'(8'h51 + i));
    chk("rsp_hold", b0.RSP_DATA, 8'hA5);
    req(0, 0, 4'd14, 8'h00);
    req(0, 1, 4'd12, 8'h77);
    req(0, 1, 4'd13, 8'h88);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge CLK);
        if ({b0.BDIR, b0.BC} == BUS_READ) begin seen = 1; break; end
      end
      chk("read_phase_seen", seen, 1);
    end
    RESET = 1;
    exp_ph.delete();
    exp_rsp.delete();
    mc_v = 0;
    @(negedge CLK);
    chk("abort_bdir", b0.BDIR, 0);
    chk("abort_bc", b0.BC, 0);
    chk("abort_busy", b0.BUSY, 0);
    chk("abort_rsp_valid", b0.RSP_VALID, 0);
    RESET = 0;
    repeat (12) @(negedge CLK);
    chk("abort_idle", b0.BUSY, 0);
    chk("queued_discarded", psg0[12], 8'h00);
    adr_t.delete();
    req(0, 1, 4'd8, 8'h0F);
    req(0, 1, 4'd8, 8'h10);
    wait_idle(0);
    chk("cache_addr_phases", adr_t.size(), EXP_AP);
    chk("psg_reg8", psg0[8], 8'h10);
    rst_pulse();
    adr_t.delete();
    req(0, 1, 4'd8, 8'h20);
    wait_idle(0);
    chk("addr_after_reset", adr_t.size(), 1);
    chk("psg_reg8_2", psg0[8], 8'h20);
    req(1, 1, 4'd1, 8'h11);
    req(1, 0, 4'd2, 8'h00);
    req(1, 1, 4'd3, 8'h33);
    req(1, 0, 4'd1, 8'h00);
    req(1, 1, 4'd2, 8'h22);
    req(1, 0, 4'd3, 8'h00);
    wait_idle(1);
    chk("bdir_rises1", rises1, 9);
    chk("psg1_reg2", psg1[2], 8'h22);
    chk("rsp_drained", exp_rsp.size(), 0);
    chk("rsp1_drained", exp_rsp1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
